// File: rtl/bch_encoder_serial.sv
// Bit-serial systematic BCH(15,7) encoder: shifts the message MSB-first through
// a division LFSR and presents {message, parity} over a valid/ready handshake.
`timescale 1ns/1ps
module bch_encoder_serial #(
  parameter int          MSG_W    = 7,
  parameter int          PAR_W    = 8,
  parameter logic [8:0]  GEN_POLY = 9'b111010001
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MSG_W-1:0]         in_msg,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MSG_W+PAR_W-1:0]   out_codeword,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [2:0]         cnt;
  logic [PAR_W-1:0]   lfsr;
  logic [MSG_W-1:0]   msg_reg;

  logic [2:0]         bit_idx;
  logic               fb;
  logic [PAR_W-1:0]   lfsr_next;

  // Message bits enter highest degree first; the x^8 term of g(x) is implicit
  // in the bit shifted out of lfsr[7].
  always_comb begin
    bit_idx   = 3'(MSG_W - 1) - cnt;
    fb        = msg_reg[bit_idx] ^ lfsr[PAR_W-1];
    lfsr_next = {lfsr[PAR_W-2:0], 1'b0} ^ (fb ? GEN_POLY[PAR_W-1:0] : '0);
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lfsr         <= '0;
      msg_reg      <= '0;
      out_valid    <= 1'b0;
      out_codeword <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_valid    <= 1'b0;
          out_codeword <= '0;
          if (in_valid) begin
            msg_reg <= in_msg;
            lfsr    <= '0;
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == 3'd7) begin
            // Counter overran the message length: abandon this encode.
            state <= IDLE;
            cnt   <= '0;
            lfsr  <= '0;
          end else begin
            lfsr <= lfsr_next;
            cnt  <= cnt + 3'd1;
            if (cnt == 3'(MSG_W - 1)) begin
              state        <= DONE;
              out_valid    <= 1'b1;
              out_codeword <= {msg_reg, lfsr_next};
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state        <= IDLE;
            out_valid    <= 1'b0;
            out_codeword <= '0;
          end
        end
        default: begin
          state        <= IDLE;
          cnt          <= '0;
          lfsr         <= '0;
          out_valid    <= 1'b0;
          out_codeword <= '0;
        end
      endcase
    end
  end

endmodule
